// File: rtl/branch_target_buffer.sv
// Branch target buffer: a direct-mapped table of branch targets with
// saturating taken/not-taken counters, and a saturating count of
// mispredicted branches.
//
// The fetch side looks the table up combinationally on lookup_pc.
// The execute side trains the table through update_en/update_pc.
//
// Optional feature, selected at compile time:
//   BTB_TAG_EN  defined   -> each entry stores pc[PC_W-1:INDEX_W] as a tag,
//                            and a hit also needs the tag to match.
//   BTB_TAG_EN  undefined -> no tag storage. Any PC with the same index
//                            hits the entry (index-only prediction).
//
// Update interface: update_en is a one-cycle strobe that has no
// backpressure. Each cycle in which update_en is high (and rst is low)
// consumes exactly one resolved branch. The table never stalls the
// execute stage.
module branch_target_buffer #(
  parameter int PC_W     = 16,
  parameter int INDEX_W  = 6,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  // fetch-side lookup
  input  logic [PC_W-1:0] lookup_pc,
  output logic            predict_taken,
  output logic [PC_W-1:0] predict_target,
  output logic            predict_hit,
  // execute-side training
  input  logic            update_en,
  input  logic [PC_W-1:0] update_pc,
  input  logic            update_taken,
  input  logic [PC_W-1:0] update_target,
  // statistics
  input  logic            stats_clear,
  output logic [15:0]     mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = PC_W - INDEX_W;

  // Counter encodings: saturated-taken, and the weakly-taken value
  // (MSB set, all other bits clear) that a new entry starts from.
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [15:0]         CNT_MAX  = 16'hFFFF;

  // ---------------------------------------------------------------------
  // Entry storage. Only the valid bits need reset. Counters, targets and
  // tags are qualified by valid, so they stay uninitialised.
  // ---------------------------------------------------------------------
  logic [ENTRIES-1:0]  valid_q;
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [PC_W-1:0]     target_q [ENTRIES];
`ifdef BTB_TAG_EN
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
`endif

  // ---------------------------------------------------------------------
  // Lookup side
  // ---------------------------------------------------------------------
  logic [INDEX_W-1:0] lk_idx;
  logic               lk_hit;

  assign lk_idx = lookup_pc[INDEX_W-1:0];

  // Hit detection for the fetch PC, using only the current stored state.
  always_comb begin
    lk_hit = valid_q[lk_idx];
`ifdef BTB_TAG_EN
    if (tag_q[lk_idx] != lookup_pc[PC_W-1:INDEX_W]) begin
      lk_hit = 1'b0;
    end
`endif
  end

  // Outputs are forced low on a miss, so reset and empty entries read as zero.
  assign predict_hit    = lk_hit;
  assign predict_taken  = lk_hit & ctr_q[lk_idx][CTR_BITS-1];
  assign predict_target = lk_hit ? target_q[lk_idx] : '0;

  // ---------------------------------------------------------------------
  // Update side: view of the entry addressed by update_pc
  // before this cycle's write.
  // ---------------------------------------------------------------------
  logic [INDEX_W-1:0]  up_idx;
  logic                up_hit;
  logic [CTR_BITS-1:0] up_ctr;
  logic [PC_W-1:0]     up_stored_target;
  logic                up_pred_taken;
  logic                up_mispredict;

  assign up_idx           = update_pc[INDEX_W-1:0];
  assign up_ctr           = ctr_q[up_idx];
  assign up_stored_target = target_q[up_idx];

  // Hit detection for the resolving branch, same rule as the lookup side.
  always_comb begin
    up_hit = valid_q[up_idx];
`ifdef BTB_TAG_EN
    if (tag_q[up_idx] != update_pc[PC_W-1:INDEX_W]) begin
      up_hit = 1'b0;
    end
`endif
  end

  assign up_pred_taken = up_hit & up_ctr[CTR_BITS-1];

  // A branch is mispredicted in two cases:
  //   - the direction was wrong, or
  //   - it was predicted taken, was taken, and went somewhere else.
  assign up_mispredict = (up_pred_taken != update_taken) ||
                         (up_pred_taken && update_taken &&
                          (up_stored_target != update_target));

`ifndef BTB_TAG_EN
  // Without tags the upper PC bits have no role in the table.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{lookup_pc[PC_W-1:INDEX_W], update_pc[PC_W-1:INDEX_W]};
`endif

  // ---------------------------------------------------------------------
  // Next-entry computation
  // ---------------------------------------------------------------------
  logic                wr_ctr;
  logic                wr_target;
  logic                alloc;
  logic [CTR_BITS-1:0] ctr_nxt;

  // Decide what the resolving branch writes: train a hit, allocate on a taken miss.
  always_comb begin
    wr_ctr    = 1'b0;
    wr_target = 1'b0;
    alloc     = 1'b0;
    ctr_nxt   = up_ctr;
    if (update_en) begin
      if (up_hit) begin
        wr_ctr = 1'b1;
        if (update_taken) begin
          wr_target = 1'b1;
          ctr_nxt   = (up_ctr == CTR_MAX) ? CTR_MAX : up_ctr + 1'b1;
        end else begin
          ctr_nxt   = (up_ctr == CTR_MIN) ? CTR_MIN : up_ctr - 1'b1;
        end
      end else if (update_taken) begin
        // A taken branch that misses claims the slot, evicting any alias.
        alloc     = 1'b1;
        wr_ctr    = 1'b1;
        wr_target = 1'b1;
        ctr_nxt   = CTR_WEAK;
      end
      // A not-taken branch that misses leaves the table untouched.
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------

  // Valid bits: cleared at once by reset, set on allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Entry payload (counter, target, tag).
  // Not reset; writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_ctr) begin
        ctr_q[up_idx] <= ctr_nxt;
      end
      if (wr_target) begin
        target_q[up_idx] <= update_target;
      end
`ifdef BTB_TAG_EN
      if (alloc) begin
        tag_q[up_idx] <= update_pc[PC_W-1:INDEX_W];
      end
`endif
    end
  end

  // Mispredict counter: saturates at all-ones. A clear wins over an
  // increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_count <= '0;
    end else if (stats_clear) begin
      mispredict_count <= '0;
    end else if (update_en && up_mispredict && (mispredict_count != CNT_MAX)) begin
      mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule
